// File: rtl/sd_wb_master_arbiter.sv
// rtl/sd_wb_master_arbiter.sv - two-requester Wishbone bus arbiter (TX/RX FIFO fillers) with beat-limited pre-emption
// Optional ack watchdog enabled by defining SD_ARB_WATCHDOG_EN.
module sd_wb_master_arbiter #(
   parameter int unsigned MAX_BEATS  = 16,
   parameter int unsigned WDT_CYCLES = 1023
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        tx_cyc_i,
   input  logic        tx_stb_i,
   input  logic        tx_we_i,
   input  logic [31:0] tx_adr_i,
   output logic [31:0] tx_dat_o,
   output logic        tx_ack_o,
   input  logic        rx_cyc_i,
   input  logic        rx_stb_i,
   input  logic        rx_we_i,
   input  logic [31:0] rx_adr_i,
   input  logic [31:0] rx_dat_i,
   output logic        rx_ack_o,
   output logic [31:0] m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   output logic [3:0]  m_wb_sel_o,
   output logic        m_wb_we_o,
   output logic        m_wb_cyc_o,
   output logic        m_wb_stb_o,
   output logic [2:0]  m_wb_cti_o,
   output logic [1:0]  m_wb_bte_o,
   input  logic [31:0] m_wb_dat_i,
   input  logic        m_wb_ack_i,
   output logic [1:0]  gnt_o,
   output logic        arb_err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GNT_TX = 2'b01,
      GNT_RX = 2'b10
   } state_e;

   localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

   state_e     state_q, state_d;
   logic       last_rx_q, last_rx_d;
   logic [7:0] beat_q, beat_d;

   logic own_cyc, own_stb, oth_cyc, bus_ack, beat_last, wdt_abort;

   assign m_wb_dat_o = rx_dat_i;
   assign tx_dat_o   = m_wb_dat_i;
   assign m_wb_sel_o = 4'b1111;
   assign m_wb_cti_o = 3'b000;
   assign m_wb_bte_o = 2'b00;
   assign gnt_o      = state_q;

   always_comb begin
      own_cyc    = 1'b0;
      own_stb    = 1'b0;
      oth_cyc    = 1'b0;
      m_wb_cyc_o = 1'b0;
      m_wb_stb_o = 1'b0;
      m_wb_we_o  = 1'b0;
      m_wb_adr_o = 32'h0;
      tx_ack_o   = 1'b0;
      rx_ack_o   = 1'b0;
      case (state_q)
         GNT_TX: begin
            own_cyc    = tx_cyc_i;
            own_stb    = tx_stb_i;
            oth_cyc    = rx_cyc_i;
            m_wb_cyc_o = tx_cyc_i;
            m_wb_stb_o = tx_stb_i;
            m_wb_we_o  = tx_we_i;
            m_wb_adr_o = tx_adr_i;
            tx_ack_o   = m_wb_ack_i;
         end
         GNT_RX: begin
            own_cyc    = rx_cyc_i;
            own_stb    = rx_stb_i;
            oth_cyc    = tx_cyc_i;
            m_wb_cyc_o = rx_cyc_i;
            m_wb_stb_o = rx_stb_i;
            m_wb_we_o  = rx_we_i;
            m_wb_adr_o = rx_adr_i;
            rx_ack_o   = m_wb_ack_i;
         end
         default: ;
      endcase
   end

   assign bus_ack   = m_wb_ack_i & (state_q != IDLE);
   // 9-bit compare so a counter saturated at 255 cannot wrap
   assign beat_last = ({1'b0, beat_q} + 9'd1) >= {1'b0, MAX_B};

`ifdef SD_ARB_WATCHDOG_EN
   localparam logic [15:0] WDT_LIM = 16'(WDT_CYCLES);

   logic [15:0] wdt_q, wdt_d;

   assign wdt_abort = (state_q != IDLE) && own_stb && !m_wb_ack_i && (wdt_q == WDT_LIM - 16'd1);
   assign arb_err_o = wdt_abort;

   always_comb begin
      wdt_d = wdt_q;
      if (state_q == IDLE || m_wb_ack_i || wdt_abort)
         wdt_d = 16'h0;
      else if (own_stb)
         wdt_d = wdt_q + 16'd1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) wdt_q <= 16'h0;
      else          wdt_q <= wdt_d;
   end
`else
   assign wdt_abort = 1'b0;
   assign arb_err_o = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      last_rx_d = last_rx_q;
      beat_d    = beat_q;
      case (state_q)
         IDLE: begin
            beat_d = 8'h0;
            if (tx_cyc_i && rx_cyc_i) state_d = last_rx_q ? GNT_TX : GNT_RX;
            else if (tx_cyc_i)        state_d = GNT_TX;
            else if (rx_cyc_i)        state_d = GNT_RX;
         end
         default: begin
            // release, watchdog abort and pre-emption all hand the next win to the other side
            if (!own_cyc || wdt_abort || (bus_ack && beat_last && oth_cyc)) begin
               state_d   = IDLE;
               last_rx_d = (state_q == GNT_RX);
               beat_d    = 8'h0;
            end else if (bus_ack && beat_q != MAX_B) begin
               beat_d = beat_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         last_rx_q <= 1'b0;
         beat_q    <= 8'h0;
      end else begin
         state_q   <= state_d;
         last_rx_q <= last_rx_d;
         beat_q    <= beat_d;
      end
   end

endmodule

// File: tb/tb_sd_wb_master_arbiter.sv
// tb/tb_sd_wb_master_arbiter.sv - bench for sd_wb_master_arbiter (MAX_BEATS=4, WDT_CYCLES=8)
module tb_sd_wb_master_arbiter;

   localparam int MB  = 4;
   localparam int WDT = 8;
`ifdef SD_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_cyc = 0, tx_stb = 0, tx_we = 0;
   logic [31:0] tx_adr = 32'h0;
   logic        rx_cyc = 0, rx_stb = 0, rx_we = 0;
   logic [31:0] rx_adr = 32'h0, rx_dat = 32'h0;
   logic [31:0] m_dat  = 32'h0;
   logic        ack_en = 1'b0;

   logic [31:0] tx_dat_o, m_wb_adr_o, m_wb_dat_o;
   logic        tx_ack_o, rx_ack_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, arb_err_o;
   logic [3:0]  m_wb_sel_o;
   logic [2:0]  m_wb_cti_o;
   logic [1:0]  m_wb_bte_o, gnt_o;
   logic        m_ack;

   // slave acknowledges only strobed cycles
   assign m_ack = ack_en & m_wb_stb_o;

   sd_wb_master_arbiter #(.MAX_BEATS(MB), .WDT_CYCLES(WDT)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .tx_cyc_i(tx_cyc), .tx_stb_i(tx_stb), .tx_we_i(tx_we), .tx_adr_i(tx_adr),
      .tx_dat_o(tx_dat_o), .tx_ack_o(tx_ack_o),
      .rx_cyc_i(rx_cyc), .rx_stb_i(rx_stb), .rx_we_i(rx_we), .rx_adr_i(rx_adr),
      .rx_dat_i(rx_dat), .rx_ack_o(rx_ack_o),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
      .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
      .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
      .m_wb_dat_i(m_dat), .m_wb_ack_i(m_ack),
      .gnt_o(gnt_o), .arb_err_o(arb_err_o)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int tx_acks = 0, rx_acks = 0, errs = 0;

   // model: owner 0 none / 1 TX / 2 RX, last 1 TX / 2 RX
   int m_owner = 0, m_last = 1, m_beats = 0, m_wdt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = 0; m_last = 1; m_beats = 0; m_wdt = 0;
      end else if (m_owner == 0) begin
         m_beats = 0; m_wdt = 0;
         if (tx_cyc && rx_cyc) m_owner = (m_last == 1) ? 2 : 1;
         else if (tx_cyc)      m_owner = 1;
         else if (rx_cyc)      m_owner = 2;
      end else begin
         bit oc, os, other, a;
         oc    = (m_owner == 1) ? tx_cyc : rx_cyc;
         os    = (m_owner == 1) ? tx_stb : rx_stb;
         other = (m_owner == 1) ? rx_cyc : tx_cyc;
         a     = ack_en && os;
         if (!oc || (WD && os && !a && m_wdt + 1 == WDT) || (a && m_beats + 1 >= MB && other)) begin
            m_last = m_owner; m_owner = 0; m_beats = 0; m_wdt = 0;
         end else if (a) begin
            m_beats = (m_beats + 1 > MB) ? MB : m_beats + 1;
            m_wdt   = 0;
         end else if (os) begin
            m_wdt = m_wdt + 1;
         end
      end
   end

   function automatic logic [112:0] expect_vec();
      logic        oc, os, ow, a, err;
      logic [31:0] oa;
      logic [1:0]  g;
      oc = 0; os = 0; ow = 0; oa = 32'h0;
      if (m_owner == 1) begin oc = tx_cyc; os = tx_stb; ow = tx_we; oa = tx_adr; end
      if (m_owner == 2) begin oc = rx_cyc; os = rx_stb; ow = rx_we; oa = rx_adr; end
      a   = ack_en && os;
      g   = 2'(m_owner);
      err = WD && (m_owner != 0) && os && !a && (m_wdt + 1 == WDT);
      return {g, oc, os, ow, oa, rx_dat, m_dat, (m_owner == 1) && a, (m_owner == 2) && a,
              4'hF, 3'b000, 2'b00, err};
   endfunction

   always @(negedge clk) begin
      logic [112:0] act, exp_v;
      act = {gnt_o, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_dat_o, tx_dat_o,
             tx_ack_o, rx_ack_o, m_wb_sel_o, m_wb_cti_o, m_wb_bte_o, arb_err_o};
      exp_v = expect_vec();
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL model_cmp t=%0t act=%h exp=%h", $time, act, exp_v);
      end
      if (tx_ack_o)  tx_acks++;
      if (rx_ack_o)  rx_acks++;
      if (arb_err_o) errs++;
   end

   task automatic chk(input string name, input longint act, input longint exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n0, lost;
      tx_we = 0; rx_we = 1;
      tx_adr = 32'h1000_0040; rx_adr = 32'h2000_0080;
      rx_dat = 32'h5A5A_0001; m_dat = 32'hCAFE_0001;
      tick(2);
      chk("rst_gnt", gnt_o, 0);
      chk("rst_cyc", m_wb_cyc_o, 0);
      rst = 0;

      // single TX request
      tx_cyc = 1; tx_stb = 1;
      tick(1);
      chk("tx_gnt", gnt_o, 1);
      chk("tx_adr", m_wb_adr_o, 32'h1000_0040);
      n0 = tx_acks;
      tick(1);
      ack_en = 1; #1;
      chk("tx_ack_now", tx_ack_o, 1);
      chk("rx_ack_quiet", rx_ack_o, 0);
      tick(1);
      ack_en = 0;
      tick(1);
      chk("tx_ack_once", tx_acks - n0, 1);
      tx_cyc = 0; tx_stb = 0;
      tick(1);
      chk("tx_release", gnt_o, 0);

      // simultaneous request after reset: RX first
      rst = 1; tick(1); rst = 0;
      rx_dat = 32'h5A5A_0002; m_dat = 32'hCAFE_0002;
      tx_cyc = 1; tx_stb = 1; rx_cyc = 1; rx_stb = 1;
      tick(1);
      chk("rx_first", gnt_o, 2);
      chk("rx_we", m_wb_we_o, 1);
      tick(2);
      rx_cyc = 0; rx_stb = 0;
      tick(1);
      chk("idle_gap", gnt_o, 0);
      chk("idle_cyc", m_wb_cyc_o, 0);
      tick(1);
      chk("tx_after_rx", gnt_o, 1);

      // TX streaming, RX pending: pre-empted after MB beats
      rx_cyc = 1; rx_stb = 1; ack_en = 1; n0 = tx_acks;
      tick(4);
      chk("preempt_idle", gnt_o, 0);
      chk("preempt_beats", tx_acks - n0, 4);
      chk("preempt_tx_ack", tx_ack_o, 0);
      tick(1);
      chk("rx_after_preempt", gnt_o, 2);
      chk("tx_stalled", tx_ack_o, 0);
      tick(1);
      rx_cyc = 0; rx_stb = 0;
      tick(1);
      chk("rx_release", gnt_o, 0);
      tick(1);
      chk("tx_resume", gnt_o, 1);

      // TX streaming alone: counter saturates, no grant loss
      n0 = tx_acks; lost = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (gnt_o != 2'b01) lost++;
      end
      chk("stream_no_loss", lost, 0);
      chk("stream_beats", tx_acks - n0, 20);

      // stall with no ack
      ack_en = 0; n0 = errs;
`ifdef SD_ARB_WATCHDOG_EN
      tick(7);
      chk("wdt_pulse", arb_err_o, 1);
      chk("wdt_pulse_gnt", gnt_o, 1);
      tick(1);
      chk("wdt_abort", gnt_o, 0);
      chk("wdt_once", errs - n0, 1);
`else
      tick(12);
      chk("no_wdt_hold", gnt_o, 1);
      chk("no_wdt_err", errs - n0, 0);
`endif
      tx_cyc = 0; tx_stb = 0;
      tick(2);

      // reset mid-burst
      tx_cyc = 1; tx_stb = 1; ack_en = 1;
      tick(1);
      chk("burst_gnt", gnt_o, 1);
      tick(2);
      rst = 1; #1;
      chk("rst_mid_cyc", m_wb_cyc_o, 0);
      chk("rst_mid_gnt", gnt_o, 0);
      chk("rst_mid_ack", tx_ack_o, 0);
      rx_cyc = 1; rx_stb = 1;
      tick(1);
      rst = 0;
      tick(1);
      chk("rst_rx_first", gnt_o, 2);
      rx_cyc = 0; rx_stb = 0; tx_cyc = 0; tx_stb = 0; ack_en = 0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_wb_master_arbiter.md
SD_WB_MASTER_ARBITER -- requirements
Module: sd_wb_master_arbiter

Interface
REQ-001 Parameter MAX_BEATS, default 16, is the number of acked beats one requester may take before it is pre-empted while the other requester waits (range 1..255).
REQ-002 Parameter WDT_CYCLES, default 1023, is the number of cycles without an ack before the watchdog aborts a grant (16-bit, used only when SD_ARB_WATCHDOG_EN is defined).
REQ-003 Port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports tx_cyc_i, tx_stb_i, tx_we_i (input, 1 bit each) and tx_adr_i (input, 32 bits): Wishbone master request from the TX FIFO filler.
REQ-006 Ports tx_dat_o (output, 32 bits) and tx_ack_o (output, 1 bit): read data and acknowledge returned to the TX filler.
REQ-007 Ports rx_cyc_i, rx_stb_i, rx_we_i (input, 1 bit each), rx_adr_i (input, 32 bits) and rx_dat_i (input, 32 bits): Wishbone master request and write data from the RX FIFO filler.
REQ-008 Port rx_ack_o, output, 1 bit: acknowledge returned to the RX filler.
REQ-009 Ports m_wb_adr_o (32 bits), m_wb_dat_o (32 bits), m_wb_sel_o (4 bits), m_wb_we_o, m_wb_cyc_o and m_wb_stb_o (1 bit each), all outputs: the shared system-bus master.
REQ-010 Ports m_wb_cti_o (3 bits) and m_wb_bte_o (2 bits), outputs: cycle-type and burst-type to the system bus.
REQ-011 Ports m_wb_dat_i (32 bits) and m_wb_ack_i (1 bit), inputs: system-bus read data and acknowledge.
REQ-012 Port gnt_o, output, 2 bits: current owner (00 none, 01 TX, 10 RX).
REQ-013 Port arb_err_o, output, 1 bit: watchdog abort pulse.

Function
REQ-014 The FSM shall have three states, IDLE, GNT_TX and GNT_RX, held in a registered grant with a 1-bit last_served flag.
REQ-015 In IDLE with only one cyc_i high, the FSM shall move to that requester's grant state on the next edge.
REQ-016 In IDLE with both tx_cyc_i and rx_cyc_i high, the FSM shall grant the requester that is not last_served; after reset RX wins first.
REQ-017 Bus outputs shall be combinational muxes of the granted requester's signals, giving one-cycle request-to-bus latency from IDLE.
REQ-018 In IDLE, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o and m_wb_adr_o shall be 0.
REQ-019 m_wb_dat_o shall always equal rx_dat_i, and tx_dat_o shall always equal m_wb_dat_i.
REQ-020 m_wb_sel_o shall be constant 4'b1111, m_wb_cti_o constant 3'b000 and m_wb_bte_o constant 2'b00.
REQ-021 m_wb_ack_i shall be routed only to the granted requester's ack_o; the non-granted ack_o shall be 0.
REQ-022 A grant shall be held while the owner's cyc_i is high; when it drops, the FSM shall return to IDLE next edge, set last_served to the owner and clear the beat counter.
REQ-023 An 8-bit beat counter shall increment on each m_wb_ack_i while granted.
REQ-024 On the ack that brings the beat counter to MAX_BEATS with the other cyc_i high, the FSM shall go to IDLE (pre-emption).
REQ-025 On pre-emption, the pre-empted requester keeps cyc/stb asserted and stalls with ack held at 0 until re-granted.
REQ-026 On the ack that brings the beat counter to MAX_BEATS with the other cyc_i low, the counter shall saturate and the grant shall continue.
REQ-027 A direct GNT_TX to GNT_RX hand-over shall never occur; IDLE always lasts at least one cycle, so m_wb_cyc_o drops for at least one cycle between owners.
REQ-028 gnt_o shall be registered and equal the FSM state encoding.

Reset
REQ-029 Asserting wb_rst_i, at any time including mid-transfer, shall immediately force IDLE, last_served = TX, beat counter 0, watchdog 0, gnt_o = 00, arb_err_o = 0 and all m_wb_* control outputs to 0.
REQ-030 After wb_rst_i deasserts, the first arbitration shall take place on the first rising edge.

Configuration
REQ-031 With SD_ARB_WATCHDOG_EN defined, a 16-bit counter shall count cycles in a grant state with stb high and m_wb_ack_i low, clearing on any ack or in IDLE.
REQ-032 With SD_ARB_WATCHDOG_EN defined, when the watchdog counter reaches WDT_CYCLES the FSM shall go to IDLE, pulse arb_err_o for one cycle and set last_served to the aborted owner.
REQ-033 With SD_ARB_WATCHDOG_EN undefined, no watchdog counter shall exist, arb_err_o shall be tied 0, and WDT_CYCLES shall be ignored.

Verification
REQ-034 Single TX: tx_cyc/stb high, ack_i on the 3rd cycle -> gnt_o=01 one cycle later; tx_ack_o pulses once; rx_ack_o stays 0.
REQ-035 Simultaneous request after reset -> RX granted first; after rx_cyc_i drops there is 1 IDLE cycle, then gnt_o=01.
REQ-036 MAX_BEATS=4, TX streaming with ack every cycle and RX pending -> exactly 4 tx_ack_o, then IDLE, then gnt_o=10; TX resumes after RX releases.
REQ-037 MAX_BEATS=4, TX streaming with RX idle -> 20 consecutive beats with no grant loss.
REQ-038 SD_ARB_WATCHDOG_EN defined, WDT_CYCLES=8, no ack -> arb_err_o pulses exactly on the 8th stalled cycle and gnt_o=00 the next cycle; with the macro undefined, arb_err_o stays 0 and the grant is held.
REQ-039 wb_rst_i pulse mid-burst -> m_wb_cyc_o=0 in the same cycle and gnt_o=00; after release the first arbitration is RX-first.
